// File: rtl/imem_boot_ctrl.sv
// rtl/imem_boot_ctrl.sv - instruction memory boot loader and fetch port owner (optional macro: IMEM_BOOT_CSUM_EN)
module imem_boot_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [7:0]        ld_byte,
    input  logic              ld_last,
    input  logic              reload,
    input  logic [31:0]       fetch_addr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic [ADDR_W:0]   word_count,
    output logic              err_overflow
`ifdef IMEM_BOOT_CSUM_EN
    ,
    output logic              err_csum
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_RUN} state_t;

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

    state_t            state;
    logic [1:0]        byte_idx;
    logic [23:0]       shift;
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       pad_word;
    logic [31:0]       wr_word;
    logic              wr_req;
    logic              unused_fetch_hi;

`ifdef IMEM_BOOT_CSUM_EN
    logic [7:0]  sum;
    logic [7:0]  sum_next;
    logic        csum_ok;
    logic [31:0] csum_word;
`endif

    assign ld_ready        = (state == S_IDLE) || (state == S_LOAD);
    assign mem_addr        = (state == S_RUN) ? fetch_addr[ADDR_W-1:0] : mem_addr_q;
    assign word_count      = wr_ptr;
    assign unused_fetch_hi = ^fetch_addr[31:ADDR_W];

    // Word formed by the incoming byte, left-aligned and zero-padded when the word is short
    always_comb begin
        pad_word = {shift, ld_byte};
        case (byte_idx)
            2'd0:    pad_word = {ld_byte, 24'h0};
            2'd1:    pad_word = {shift[7:0], ld_byte, 16'h0};
            2'd2:    pad_word = {shift[15:0], ld_byte, 8'h0};
            default: pad_word = {shift, ld_byte};
        endcase
    end

`ifdef IMEM_BOOT_CSUM_EN
    // Running modulo-256 sum and the partial data word that precedes the checksum byte
    always_comb begin
        sum_next = ((state == S_IDLE) ? 8'd0 : sum) + ld_byte;
        csum_ok  = (sum_next == 8'd0);
        case (byte_idx)
            2'd1:    csum_word = {shift[7:0], 24'h0};
            2'd2:    csum_word = {shift[15:0], 16'h0};
            2'd3:    csum_word = {shift[23:0], 8'h0};
            default: csum_word = 32'h0;
        endcase
    end
`endif

    // Decide whether the accepted byte completes a word that must be written next cycle
    always_comb begin
        wr_req  = 1'b0;
        wr_word = pad_word;
        if (ld_valid && ld_ready) begin
`ifdef IMEM_BOOT_CSUM_EN
            if (ld_last) begin
                wr_req  = csum_ok && (byte_idx != 2'd0);
                wr_word = csum_word;
            end else begin
                wr_req  = (byte_idx == 2'd3);
            end
`else
            wr_req = ld_last || (byte_idx == 2'd3);
`endif
        end
    end

    // Load sequencing, registered memory write port and core reset control
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            byte_idx     <= 2'd0;
            shift        <= 24'h0;
            wr_ptr       <= '0;
            mem_addr_q   <= '0;
            mem_we       <= 1'b0;
            mem_wdata    <= 32'h0;
            cpu_rst      <= 1'b1;
            load_done    <= 1'b0;
            err_overflow <= 1'b0;
`ifdef IMEM_BOOT_CSUM_EN
            sum          <= 8'h0;
            err_csum     <= 1'b0;
`endif
        end else begin
            mem_we    <= 1'b0;
            mem_wdata <= 32'h0;
            case (state)
                S_IDLE, S_LOAD: begin
                    if (ld_valid) begin
                        shift    <= {shift[15:0], ld_byte};
                        byte_idx <= byte_idx + 2'd1;
                        state    <= S_LOAD;
`ifdef IMEM_BOOT_CSUM_EN
                        sum <= sum_next;
                        if (state == S_IDLE) err_csum <= 1'b0;
                        if (ld_last) begin
                            byte_idx <= 2'd0;
                            if (csum_ok) begin
                                state <= S_FLUSH;
                            end else begin
                                // Bad image: keep the core in reset and restart from word 0
                                state    <= S_IDLE;
                                err_csum <= 1'b1;
                                wr_ptr   <= '0;
                            end
                        end
`else
                        if (ld_last) begin
                            byte_idx <= 2'd0;
                            state    <= S_FLUSH;
                        end
`endif
                    end
                end
                S_FLUSH: begin
                    state     <= S_RUN;
                    cpu_rst   <= 1'b0;
                    load_done <= 1'b1;
                end
                default: begin
                    if (reload) begin
                        state        <= S_IDLE;
                        cpu_rst      <= 1'b1;
                        load_done    <= 1'b0;
                        wr_ptr       <= '0;
                        byte_idx     <= 2'd0;
                        err_overflow <= 1'b0;
                    end
                end
            endcase
            if (wr_req) begin
                if (wr_ptr == DEPTH_W) begin
                    err_overflow <= 1'b1;
                end else begin
                    mem_we     <= 1'b1;
                    mem_addr_q <= wr_ptr[ADDR_W-1:0];
                    mem_wdata  <= wr_word;
                    wr_ptr     <= wr_ptr + PTR_ONE;
                end
            end
        end
    end

endmodule

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
- Owns the single port of the instruction memory and shares it between a byte-stream program loader and the fetch stage.
- After reset, holds the core in reset and assembles incoming bytes into 32-bit big-endian instruction words, writing them to consecutive word addresses from 0.
- When the load completes, releases the core and passes the PC-driven fetch address straight through to the memory.
- Replaces hand-edited initial-block programs with a runtime load path.

Parameters:
- ADDR_W, 10, word-address width of the instruction memory.
- DEPTH, 1024, number of 32-bit words; the highest writable index is DEPTH-1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ld_valid  in  1  loader byte valid.
- ld_ready  out  1  controller can accept a byte.
- ld_byte  in  8  program byte; the first byte of each word is bits 31:24.
- ld_last  in  1  marks the final byte of the stream; qualified by ld_valid.
- reload  in  1  single-cycle request to reload the program; honoured only in RUN.
- fetch_addr  in  32  word index from the PC; bits ADDR_W-1:0 are used.
- mem_we  out  1  instruction-memory write enable.
- mem_addr  out  ADDR_W  instruction-memory address.
- mem_wdata  out  32  instruction-memory write data.
- cpu_rst  out  1  holds the core in reset; active high.
- load_done  out  1  high while in RUN.
- word_count  out  ADDR_W+1  number of words written in the last load.
- err_overflow  out  1  sticky; the stream exceeded DEPTH words.

Behaviour:
- Reset values:
  - state = IDLE; byte_idx = 0; wr_ptr = 0; word_count = 0; shift = 0.
  - mem_we = 0; mem_wdata = 0; mem_addr = 0.
  - cpu_rst = 1; load_done = 0; err_overflow = 0.
- States: IDLE, LOAD, FLUSH, RUN.
- ld_ready = 1 in IDLE and LOAD; 0 in FLUSH and RUN. A byte is accepted when ld_valid && ld_ready.
- IDLE: the first accepted byte enters LOAD and is processed exactly as a LOAD byte.
- LOAD, byte assembly:
  - Each accepted byte shifts into {shift[23:0], ld_byte}; byte_idx increments modulo 4.
  - On the 4th byte of a word, the next cycle has mem_we = 1, mem_addr = wr_ptr, mem_wdata = the assembled word.
  - wr_ptr and word_count then increment. Write latency is 1 cycle after the 4th byte is accepted.
  - Back-to-back bytes are legal; a write pulse overlaps acceptance of the next byte.
- ld_last accepted → FLUSH.
  - If byte_idx != 0 after the last byte, the partial word is left-aligned and zero-padded in the low bytes (e.g. 3 bytes AA BB CC → 0xAABBCC00).
  - That word is written in FLUSH.
- Overflow: when wr_ptr == DEPTH, further words are not written (mem_we stays 0), err_overflow is set, and word_count saturates at DEPTH. Loading continues to ld_last.
- FLUSH: lasts 1 cycle, performs the pending write if any, then moves to RUN.
- RUN:
  - cpu_rst = 0 and load_done = 1 starting in the first RUN cycle.
  - mem_we = 0; mem_addr = fetch_addr[ADDR_W-1:0] combinationally, with zero added latency; mem_wdata is don't-care (driven 0).
- reload in RUN: next state is IDLE; cpu_rst = 1 and load_done = 0 the following cycle; wr_ptr, byte_idx, word_count and err_overflow are cleared. reload outside RUN is ignored.
- rst asserted mid-load: the state is abandoned immediately and reset values apply on the next edge. Words already written remain in memory.
- An empty stream (ld_last on the first byte) writes exactly one word.

Optional Feature:
- Macro: IMEM_BOOT_CSUM_EN.
- When defined:
  - The byte flagged ld_last is a checksum and is neither stored nor counted.
  - The 8-bit modulo-256 sum of all accepted bytes, including the checksum byte, must equal 0x00.
  - On mismatch, add output err_csum (1 bit, sticky, reset 0) = 1, and the controller goes to IDLE instead of FLUSH with cpu_rst held. A partial word before the checksum is still written via FLUSH only on match.
  - err_csum clears on rst or on the first byte accepted in IDLE.
- When undefined: ld_last marks a data byte, and the err_csum port does not exist.

Test Plan:
- Reset, then stream 8C 08 00 00 8C 09 00 08 with ld_last on the final byte → mem[0]=0x8C080000 and mem[1]=0x8C090008; word_count=2; cpu_rst falls 1 cycle after the FLUSH cycle.
- Stream 20 01 00 02 AA BB with last on BB → mem[1]=0xAABB0000; word_count=2.
- In RUN, drive fetch_addr=3 → mem_addr=3 the same cycle; mem_we=0; ld_ready=0 with ld_valid held high.
- Parameter DEPTH=4; stream 20 bytes → 4 writes only; err_overflow=1; word_count=4; RUN is reached.
- In RUN, pulse reload, then load 4 bytes → cpu_rst=1 the cycle after reload; word_count=1; err_overflow=0; mem[0] is overwritten.
- Assert rst after 2 bytes of a word → no write occurs; state=IDLE; the next 4 bytes write mem[0].
- With IMEM_BOOT_CSUM_EN: stream 01 02 03 04 F6 → mem[0]=0x01020304 and RUN is reached; changing the checksum to F5 → err_csum=1, cpu_rst stays 1, state=IDLE.
